// File: rtl/cape_gpio_irq.sv
// GPIO edge-interrupt controller: sync, optional debounce (CAPE_GPIO_DEBOUNCE_EN), W1C pending, APB3 regs.
// Latency: pad edge to INT_* high is SYNC_STAGES+2 cycles (plus DB_TICKS when debounce is built in).
// Backpressure: none; APB is zero-wait, reads are loaded at the setup edge.
module cape_gpio_irq #(
   parameter int N_GPIO      = 28,
   parameter int SYNC_STAGES = 2,
   parameter int DB_WIDTH    = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [7:0]        PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   input  logic [N_GPIO-1:0] GPIO_IN,
   output logic [7:0]        INT_A,
   output logic [7:0]        INT_B,
   output logic [7:0]        INT_C
);

   logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
   logic [N_GPIO-1:0] s;
   logic [N_GPIO-1:0] f;
   logic [N_GPIO-1:0] prev;
   logic [N_GPIO-1:0] irq_en;
   logic [N_GPIO-1:0] rise_en;
   logic [N_GPIO-1:0] fall_en;
   logic [N_GPIO-1:0] pend;
   logic [N_GPIO-1:0] pend_set;
   logic [N_GPIO-1:0] pend_clr;
   logic [N_GPIO-1:0] masked;
   logic [31:0]       rdata;
   logic [5:0]        reg_sel;
   logic              wr_en;
   logic              rd_setup;

   assign reg_sel  = PADDR[7:2];
   assign wr_en    = PSEL & PENABLE & PWRITE;
   assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= GPIO_IN;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef CAPE_GPIO_DEBOUNCE_EN
   logic [DB_WIDTH-1:0] db_ticks;
   logic [DB_WIDTH-1:0] db_cnt [N_GPIO];
   logic [N_GPIO-1:0]   filt_q;

   // filt_q shadows s while bypassed so re-enabling the filter cannot fabricate an edge
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         filt_q <= '0;
         for (int i = 0; i < N_GPIO; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_GPIO; i++) begin
            if (db_ticks == '0 || s[i] == filt_q[i]) begin
               filt_q[i] <= s[i];
               db_cnt[i] <= '0;
            end else if (db_cnt[i] >= db_ticks - DB_WIDTH'(1)) begin
               filt_q[i] <= s[i];
               db_cnt[i] <= '0;
            end else if (db_cnt[i] != '1) begin
               db_cnt[i] <= db_cnt[i] + DB_WIDTH'(1);
            end
         end
      end
   end

   assign f = (db_ticks == '0) ? s : filt_q;

   always_ff @(posedge PCLK) begin
      if (PRESET)
         db_ticks <= '0;
      else if (wr_en && reg_sel == 6'h05)
         db_ticks <= PWDATA[DB_WIDTH-1:0];
   end
`else
   logic [DB_WIDTH-1:0] unused_db;
   assign unused_db = '0;
   assign f = s;
`endif

   assign pend_set = (f & ~prev & rise_en) | (~f & prev & fall_en);
   assign pend_clr = (wr_en && reg_sel == 6'h04) ? PWDATA[N_GPIO-1:0] : '0;
   assign masked   = pend & irq_en;

   always_comb begin
      rdata = '0;
      case (reg_sel)
         6'h00:   rdata[N_GPIO-1:0] = s;
         6'h01:   rdata[N_GPIO-1:0] = irq_en;
         6'h02:   rdata[N_GPIO-1:0] = rise_en;
         6'h03:   rdata[N_GPIO-1:0] = fall_en;
         6'h04:   rdata[N_GPIO-1:0] = pend;
`ifdef CAPE_GPIO_DEBOUNCE_EN
         6'h05:   rdata[DB_WIDTH-1:0] = db_ticks;
`endif
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         prev    <= '0;
         irq_en  <= '0;
         rise_en <= '0;
         fall_en <= '0;
         pend    <= '0;
         INT_A   <= '0;
         INT_B   <= '0;
         INT_C   <= '0;
         PRDATA  <= '0;
      end else begin
         prev <= f;
         if (wr_en && reg_sel == 6'h01) irq_en  <= PWDATA[N_GPIO-1:0];
         if (wr_en && reg_sel == 6'h02) rise_en <= PWDATA[N_GPIO-1:0];
         if (wr_en && reg_sel == 6'h03) fall_en <= PWDATA[N_GPIO-1:0];
         // a new edge in the same cycle as its W1C keeps the bit pending
         pend  <= (pend & ~pend_clr) | pend_set;
         INT_A <= masked[7:0];
         INT_B <= masked[15:8];
         INT_C <= {|masked[27:23], masked[22:16]};
         if (rd_setup) PRDATA <= rdata;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{PWDATA[31:N_GPIO], PADDR[1:0]};

endmodule

// File: tb/tb_cape_gpio_irq.sv
// Directed bench for cape_gpio_irq: register table plus hand-built interrupt timing sequences.
module tb_cape_gpio_irq;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        PSEL, PENABLE, PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic [27:0] GPIO_IN;
   logic [7:0]  INT_A, INT_B, INT_C;

   int total = 0;
   int bad   = 0;

   always #5 PCLK = ~PCLK;

   cape_gpio_irq dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .GPIO_IN(GPIO_IN),
      .INT_A(INT_A), .INT_B(INT_B), .INT_C(INT_C)
   );

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [17];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // all tasks start and end on a falling edge
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      @(negedge PCLK);
      d = PRDATA;
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(a, d);
      check(nm, d, exp);
   endtask

   initial begin
      vt[0]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
      vt[1]  = '{1'b0, 8'h04, 32'h0,         32'h0FFF_FFFF};
      vt[2]  = '{1'b1, 8'h08, 32'h1234_5678, 32'h0};
      vt[3]  = '{1'b0, 8'h08, 32'h0,         32'h0234_5678};
      vt[4]  = '{1'b1, 8'h0C, 32'hA5A5_A5A5, 32'h0};
      vt[5]  = '{1'b0, 8'h0C, 32'h0,         32'h05A5_A5A5};
      vt[6]  = '{1'b0, 8'h07, 32'h0,         32'h0FFF_FFFF};
      vt[7]  = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0};
      vt[8]  = '{1'b0, 8'h00, 32'h0,         32'h0};
      vt[9]  = '{1'b1, 8'h18, 32'hFFFF_FFFF, 32'h0};
      vt[10] = '{1'b0, 8'h18, 32'h0,         32'h0};
      vt[11] = '{1'b0, 8'h10, 32'h0,         32'h0};
      vt[12] = '{1'b0, 8'hFC, 32'h0,         32'h0};
      vt[13] = '{1'b1, 8'h04, 32'h0,         32'h0};
      vt[14] = '{1'b1, 8'h08, 32'h0,         32'h0};
      vt[15] = '{1'b1, 8'h0C, 32'h0,         32'h0};
      vt[16] = '{1'b0, 8'h04, 32'h0,         32'h0};

      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; GPIO_IN = '0;

      // T1: reset state
      repeat (3) @(negedge PCLK);
      check("t1_prdata", PRDATA, 32'h0);
      check("t1_int", {8'h0, INT_A, INT_B, INT_C}, 32'h0);
      PRESET = 1'b0;
      rd_chk("t1_in",      8'h00, 32'h0);
      rd_chk("t1_irq_en",  8'h04, 32'h0);
      rd_chk("t1_rise_en", 8'h08, 32'h0);
      rd_chk("t1_fall_en", 8'h0C, 32'h0);
      rd_chk("t1_status",  8'h10, 32'h0);
      rd_chk("t1_db",      8'h14, 32'h0);

      // register map table
      for (int i = 0; i < 17; i++) begin
         if (vt[i].wr) apb_write(vt[i].addr, vt[i].data);
         else          rd_chk($sformatf("tbl%0d", i), vt[i].addr, vt[i].exp);
      end

      // T2: rising edge on bit 0, latency, W1C
      apb_write(8'h08, 32'h1);
      apb_write(8'h04, 32'h1);
      GPIO_IN[0] = 1'b1;
      repeat (3) @(negedge PCLK);
      check("t2_int_early", {24'h0, INT_A}, 32'h0);
      @(negedge PCLK);
      check("t2_int_lat4", {24'h0, INT_A}, 32'h1);
      rd_chk("t2_status", 8'h10, 32'h1);
      rd_chk("t2_in",     8'h00, 32'h1);
      apb_write(8'h10, 32'h1);
      check("t2_int_hold", {24'h0, INT_A}, 32'h1);
      @(negedge PCLK);
      check("t2_int_clr", {24'h0, INT_A}, 32'h0);
      rd_chk("t2_status_clr", 8'h10, 32'h0);

      // T3: falling edges on 27 and 23 share INT_C[7]
      apb_write(8'h08, 32'h0);
      apb_write(8'h0C, 32'h0880_0000);
      apb_write(8'h04, 32'h0880_0000);
      GPIO_IN[27] = 1'b1;
      repeat (4) @(negedge PCLK);
      check("t3_no_rise", {24'h0, INT_C}, 32'h0);
      GPIO_IN[27] = 1'b0;
      repeat (5) @(negedge PCLK);
      check("t3_int_c27", {24'h0, INT_C}, 32'h80);
      rd_chk("t3_status27", 8'h10, 32'h0800_0000);
      GPIO_IN[23] = 1'b1;
      repeat (4) @(negedge PCLK);
      GPIO_IN[23] = 1'b0;
      repeat (5) @(negedge PCLK);
      rd_chk("t3_status_both", 8'h10, 32'h0880_0000);
      apb_write(8'h10, 32'h0800_0000);
      repeat (2) @(negedge PCLK);
      check("t3_int_c_stays", {24'h0, INT_C}, 32'h80);
      rd_chk("t3_status23", 8'h10, 32'h0080_0000);
      apb_write(8'h10, 32'h0080_0000);
      repeat (2) @(negedge PCLK);
      check("t3_int_c_clr", {24'h0, INT_C}, 32'h0);

      // T4: W1C lands on the same edge that sets bit 5
      apb_write(8'h0C, 32'h0);
      apb_write(8'h08, 32'h20);
      apb_write(8'h04, 32'h20);
      GPIO_IN[5] = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 8'h10; PWDATA = 32'h20;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      rd_chk("t4_set_wins", 8'h10, 32'h20);
      check("t4_int_a5", {24'h0, INT_A}, 32'h20);
      apb_write(8'h10, 32'h20);
      rd_chk("t4_status_clr", 8'h10, 32'h0);

`ifdef CAPE_GPIO_DEBOUNCE_EN
      // T5: debounce rejects a short glitch, accepts a long level
      apb_write(8'h14, 32'd10);
      rd_chk("t5_db_ticks", 8'h14, 32'd10);
      apb_write(8'h08, 32'h8);
      apb_write(8'h04, 32'h8);
      GPIO_IN[3] = 1'b1;
      repeat (5) @(negedge PCLK);
      GPIO_IN[3] = 1'b0;
      repeat (20) @(negedge PCLK);
      rd_chk("t5_glitch", 8'h10, 32'h0);
      GPIO_IN[3] = 1'b1;
      repeat (12) @(negedge PCLK);
      repeat (5) @(negedge PCLK);
      rd_chk("t5_level", 8'h10, 32'h8);
      apb_write(8'h10, 32'h8);
      apb_write(8'h14, 32'h0);
`endif

      // T6: reset with every pin pending
      apb_write(8'h08, 32'h0FFF_FFFF);
      apb_write(8'h0C, 32'h0FFF_FFFF);
      apb_write(8'h04, 32'h0FFF_FFFF);
      GPIO_IN = ~GPIO_IN;
      repeat (5) @(negedge PCLK);
      rd_chk("t6_status_all", 8'h10, 32'h0FFF_FFFF);
      check("t6_int_all", {8'h0, INT_A, INT_B, INT_C}, 32'h00FF_FFFF);
      PRESET = 1'b1;
      GPIO_IN = '0;
      @(negedge PCLK);
      check("t6_int_rst", {8'h0, INT_A, INT_B, INT_C}, 32'h0);
      check("t6_prdata_rst", PRDATA, 32'h0);
      PRESET = 1'b0;
      rd_chk("t6_irq_en",  8'h04, 32'h0);
      rd_chk("t6_rise_en", 8'h08, 32'h0);
      rd_chk("t6_fall_en", 8'h0C, 32'h0);
      rd_chk("t6_status",  8'h10, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
